cb_dina_map: RTL and testbench
==============================

Name: cb_dina_map

Overview:
- Write-side counterpart of the CB read-port lane mapper.
- Takes result vectors streamed from the RSA output lanes and remaps them onto the L cache-bank data lanes of CB port A, using the same direction codes as the read path.
- Generates per-bank write enables and a sequential write address from a single burst command.
- Sits between the RSA result drain and CB port A; the top-level sequencer issues one command per write-back burst.

Parameters:
- X, 4, RSA output lane count; must equal L.
- L, 4, cache-bank lane count on CB port A.
- RSA_DW, 16, data width per lane.
- ROW_LEN, 10, maximum burst length; sets LEN_W = clog2(ROW_LEN+1).
- CB_AW, 10, CB address width.

Ports:
- clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  2  00 DIR_IDLE, 01 DIR_POS, 10 DIR_NEW_0, 11 DIR_NEW_1
- cmd_base  in  CB_AW  first write address
- cmd_len  in  LEN_W  number of vectors to write
- in_valid  in  1  RSA result vector valid
- in_ready  out  1  vector accepted this cycle when in_valid is also high
- in_data  in  X*RSA_DW  RSA result vector; lane k at [k*RSA_DW +: RSA_DW]
- CB_ena  out  1  port A enable
- CB_wea  out  L  per-bank write enable
- CB_addra  out  CB_AW  write address
- CB_dina  out  L*RSA_DW  write data
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the counter is 0. This applies in any state; an in-flight burst is abandoned, no done pulse is issued, and no CB write occurs in the cycle after reset is asserted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On cmd_valid, latch dir, base and len, and clear cnt.
  - If dir==DIR_IDLE or len==0, go to DONE; otherwise go to RUN.
- RUN:
  - cmd_ready=0, in_ready=1 (combinational from state).
  - Each handshake (in_valid & in_ready) performs one write, registered; outputs appear the cycle after the handshake:
    - CB_ena=1
    - CB_addra = base + cnt, truncated to CB_AW (wraps modulo 2^CB_AW)
    - cnt increments
  - Lane mapping for each write:
    - DIR_POS: CB_dina = in_data; CB_wea = all ones.
    - DIR_NEW_1: banks 0,1 = lanes 0,1; banks 2,3 = 0; CB_wea = 4'b0011.
    - DIR_NEW_0: banks 2,3 = lanes 0,1; banks 0,1 = 0; CB_wea = 4'b1100.
    - Lanes 2,3 of in_data are ignored in both NEW modes.
  - When the handshake makes cnt equal len, go to DONE.
  - A cycle without a handshake drives CB_ena=0, CB_wea=0 and CB_dina=0; CB_addra holds its value.
- DONE:
  - done=1 for exactly this cycle; in_ready=0, cmd_ready=0.
  - Always go to IDLE.
  - The next command can be accepted no earlier than the cycle after done. The last write and done occur in the same cycle.
- Command latency: cmd handshake to first possible in_ready is 1 cycle; a DIR_IDLE or len==0 command pulses done 1 cycle after the cmd handshake.
- Back-to-back vectors: with in_valid held high, one write is issued per cycle with no bubbles.
- cmd_valid is ignored outside IDLE; in_valid is ignored outside RUN.
- cmd_len > ROW_LEN is not legal; the block still counts to len.

Test Plan:
1. POS burst: base=0x010, len=3, vectors {1,2,3,4},{5,6,7,8},{9,10,11,12} back-to-back → writes at 0x010/0x011/0x012, CB_wea=1111 each, data unchanged; done pulses in the same cycle as the write to 0x012.
2. NEW_0 burst: base=0x020, len=2, in lanes {A,B,C,D} → CB_dina banks {0,0,A,B}, CB_wea=1100, addresses 0x020, 0x021.
3. NEW_1 with in_valid gaps: len=2, in_valid toggling 1,0,0,1 → exactly 2 writes with CB_wea=0011, and CB_ena=0 in the gap cycles; done follows the second write.
4. Degenerate commands: DIR_IDLE with len=5, and DIR_POS with len=0 → no CB_ena, done exactly 1 cycle after the cmd handshake, cmd_ready back high the next cycle.
5. Wrap: base = 2^CB_AW−1, len=2 → addresses 0x3FF, then 0x000.
6. Reset mid-burst: sys_rst after 1 of 4 writes → all outputs 0 the next cycle, no done; a subsequent POS len=1 command completes normally starting at its own base.

Source files
------------

// File: rtl/cb_dina_map.sv
// Write-side lane mapper for CB port A: turns one burst command plus a stream of
// RSA result vectors into registered per-bank writes at sequential addresses.
module cb_dina_map #(
  parameter int X       = 4,
  parameter int L       = 4,
  parameter int RSA_DW  = 16,
  parameter int ROW_LEN = 10,
  parameter int CB_AW   = 10,
  localparam int LEN_W  = $clog2(ROW_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_dir,
  input  logic [CB_AW-1:0]      cmd_base,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X*RSA_DW-1:0]   in_data,
  output logic                  CB_ena,
  output logic [L-1:0]          CB_wea,
  output logic [CB_AW-1:0]      CB_addra,
  output logic [L*RSA_DW-1:0]   CB_dina,
  output logic                  done
);

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_POS   = 2'b01;
  localparam logic [1:0] DIR_NEW_0 = 2'b10;
  localparam logic [1:0] DIR_NEW_1 = 2'b11;
  localparam int HALF = L / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [CB_AW-1:0]   base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               wr_fire;
  logic [L-1:0]       map_wea;
  logic [L*RSA_DW-1:0] map_data;

  // Lower banks take the low lanes in NEW_1; upper banks take the same low lanes in NEW_0.
  for (genvar gi = 0; gi < L; gi++) begin : g_bank
    if (gi < HALF) begin : g_lo
      assign map_wea[gi] = (dir_q == DIR_POS) || (dir_q == DIR_NEW_1);
      assign map_data[gi*RSA_DW +: RSA_DW] = map_wea[gi] ? in_data[gi*RSA_DW +: RSA_DW] : '0;
    end else begin : g_hi
      assign map_wea[gi] = (dir_q == DIR_POS) || (dir_q == DIR_NEW_0);
      assign map_data[gi*RSA_DW +: RSA_DW] =
          (dir_q == DIR_POS)   ? in_data[gi*RSA_DW +: RSA_DW] :
          (dir_q == DIR_NEW_0) ? in_data[(gi-HALF)*RSA_DW +: RSA_DW] : '0;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !sys_rst;
  assign in_ready  = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wr_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          base_d  = cmd_base;
          len_d   = cmd_len;
          cnt_d   = '0;
          state_d = (cmd_dir == DIR_IDLE || cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          wr_fire = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      dir_q    <= DIR_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      CB_ena   <= 1'b0;
      CB_wea   <= '0;
      CB_addra <= '0;
      CB_dina  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      CB_ena  <= wr_fire;
      CB_wea  <= wr_fire ? map_wea : '0;
      CB_dina <= wr_fire ? map_data : '0;
      if (wr_fire) CB_addra <= base_q + CB_AW'(cnt_q);
    end
  end

endmodule

// File: tb/tb_cb_dina_map.sv
// Self-checking bench for cb_dina_map: expected writes are queued at each vector
// handshake and matched against CB port A by a negedge monitor.
module tb_cb_dina_map;
  localparam int DW = 16;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dir;
  logic [9:0]  cmd_base;
  logic [3:0]  cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        CB_ena;
  logic [3:0]  CB_wea;
  logic [9:0]  CB_addra;
  logic [63:0] CB_dina;
  logic        done;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  wea;
    logic [63:0] dina;
    logic        last;
  } wr_t;
  wr_t sb[$];

  cb_dina_map dut (
    .clk(clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .CB_ena(CB_ena), .CB_wea(CB_wea), .CB_addra(CB_addra), .CB_dina(CB_dina),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Reference lane map: POS passes through; NEW_1 keeps lanes 0,1 in banks 0,1;
  // NEW_0 moves lanes 0,1 into banks 2,3.
  function automatic wr_t expect_wr(input logic [1:0] dir, input logic [9:0] addr,
                                    input logic [63:0] data, input logic last);
    wr_t w;
    w.addr = addr;
    w.last = last;
    case (dir)
      2'b01:   begin w.wea = 4'b1111; w.dina = data; end
      2'b11:   begin w.wea = 4'b0011; w.dina = {32'h0, data[31:0]}; end
      2'b10:   begin w.wea = 4'b1100; w.dina = {data[31:0], 32'h0}; end
      default: begin w.wea = 4'b0000; w.dina = 64'h0; end
    endcase
    return w;
  endfunction

  // Scoreboard monitor: every CB write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (CB_ena === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h wea=%b dina=%h", CB_addra, CB_wea, CB_dina);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (CB_addra !== e.addr || CB_wea !== e.wea || CB_dina !== e.dina || done !== e.last) begin
            errors++;
            $display("FAIL write got addr=%h wea=%b dina=%h done=%b exp addr=%h wea=%b dina=%h done=%b",
                     CB_addra, CB_wea, CB_dina, done, e.addr, e.wea, e.dina, e.last);
          end else
            $display("write addr=%h wea=%b dina=%h done=%b ok", CB_addra, CB_wea, CB_dina, done);
        end
      end else begin
        checks++;
        if (CB_ena !== 1'b0 || CB_wea !== 4'b0 || CB_dina !== 64'h0) begin
          errors++;
          $display("FAIL idle_bus got ena=%b wea=%b dina=%h exp 0/0/0", CB_ena, CB_wea, CB_dina);
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] dir, input logic [9:0] base, input logic [3:0] len);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_timeout got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_dir = dir; cmd_base = base; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd dir=%b base=%h len=%0d", dir, base, len);
  endtask

  task automatic send_vec(input logic [1:0] dir, input logic [9:0] addr,
                          input logic [63:0] data, input logic last);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready got %b exp 1", in_ready);
    end
    in_valid = 1'b1; in_data = data;
    sb.push_back(expect_wr(dir, addr, data, last));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_burst_end(input string name);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got done=%b cmd_ready=%b in_ready=%b exp 1/0/0", name, done, cmd_ready, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || CB_ena !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_after got done=%b cmd_ready=%b ena=%b pending=%0d exp 0/1/0/0",
               name, done, cmd_ready, CB_ena, sb.size());
    end
    $display("%s complete", name);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (CB_ena !== 1'b0 || CB_wea !== 4'b0 || CB_addra !== 10'h0 || CB_dina !== 64'h0 ||
        done !== 1'b0 || cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ena=%b wea=%b addr=%h dina=%h done=%b cmd_ready=%b in_ready=%b exp all 0",
               CB_ena, CB_wea, CB_addra, CB_dina, done, cmd_ready, in_ready);
    end
    sys_rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got cmd_ready=%b in_ready=%b exp 1/0", cmd_ready, in_ready);
    end
    mon_en = 1'b1;
    $display("reset ok");
  endtask

  task automatic test_pos_burst();
    send_cmd(2'b01, 10'h010, 4'd3);
    for (int i = 0; i < 3; i++)
      send_vec(2'b01, 10'h010 + 10'(i), pack(4*i+1, 4*i+2, 4*i+3, 4*i+4), i == 2);
    check_burst_end("pos");
  endtask

  task automatic test_new0_burst();
    send_cmd(2'b10, 10'h020, 4'd2);
    send_vec(2'b10, 10'h020, pack('hA, 'hB, 'hC, 'hD), 1'b0);
    send_vec(2'b10, 10'h021, pack('h1A, 'h1B, 'h1C, 'h1D), 1'b1);
    check_burst_end("new0");
  endtask

  task automatic test_new1_gaps();
    send_cmd(2'b11, 10'h030, 4'd2);
    send_vec(2'b11, 10'h030, pack('h111, 'h222, 'h333, 'h444), 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_data = pack('hBAD, 'hBAD, 'hBAD, 'hBAD);
      @(posedge clk); #1;
      checks++;
      if (CB_ena !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap%0d got ena=%b done=%b in_ready=%b exp 0/0/1", i, CB_ena, done, in_ready);
      end
    end
    send_vec(2'b11, 10'h031, pack('h555, 'h666, 'h777, 'h888), 1'b1);
    check_burst_end("new1_gaps");
  endtask

  task automatic test_degenerate();
    logic [1:0] dirs [2];
    logic [3:0] lens [2];
    dirs[0] = 2'b00; lens[0] = 4'd5;
    dirs[1] = 2'b01; lens[1] = 4'd0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      send_cmd(dirs[k], 10'h0AA, lens[k]);
      checks++;
      if (CB_ena !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL degen%0d_nowrite got ena=%b in_ready=%b exp 0/0", k, CB_ena, in_ready);
      end
      in_valid = 1'b0;
      check_burst_end("degenerate");
    end
  endtask

  task automatic test_wrap();
    send_cmd(2'b01, 10'h3FF, 4'd2);
    send_vec(2'b01, 10'h3FF, pack(7, 8, 9, 10), 1'b0);
    send_vec(2'b01, 10'h000, pack(11, 12, 13, 14), 1'b1);
    check_burst_end("wrap");
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(2'b01, 10'h040, 4'd4);
    send_vec(2'b01, 10'h040, pack(21, 22, 23, 24), 1'b0);
    sys_rst = 1'b1;
    in_valid = 1'b1;
    in_data = pack(31, 32, 33, 34);
    @(posedge clk); #1;
    checks++;
    if (CB_ena !== 1'b0 || CB_wea !== 4'b0 || CB_addra !== 10'h0 || CB_dina !== 64'h0 ||
        done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got ena=%b wea=%b addr=%h dina=%h done=%b in_ready=%b exp all 0",
               CB_ena, CB_wea, CB_addra, CB_dina, done, in_ready);
    end
    sys_rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || CB_ena !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle got done=%b ena=%b cmd_ready=%b exp 0/0/1", done, CB_ena, cmd_ready);
    end
    send_cmd(2'b01, 10'h050, 4'd1);
    send_vec(2'b01, 10'h050, pack(41, 42, 43, 44), 1'b1);
    check_burst_end("after_reset");
  endtask

  initial begin
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_base = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0;
    test_reset();
    test_pos_burst();
    test_new0_burst();
    test_new1_gaps();
    test_degenerate();
    test_wrap();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got %0d exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
